// File: rtl/led_blink_arbiter.sv
// Round-robin owner of the single status LED: each granted requester flashes
// its latched blink count (ON/OFF pulses) followed by an enforced dark gap.
module led_blink_arbiter #(
    parameter int NREQ      = 4,
    parameter int CNT_W     = 4,
    parameter int TICK_DIV  = 25000,
    parameter int ON_TICKS  = 200,
    parameter int OFF_TICKS = 200,
    parameter int GAP_TICKS = 1000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*CNT_W-1:0]     count,
    output logic [NREQ-1:0]           ack,
    output logic                      done,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      led
);

    localparam int GW   = $clog2(NREQ);
    localparam int PW   = $clog2(TICK_DIV);
    localparam int MAXT = (ON_TICKS > OFF_TICKS)
                        ? ((ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS)
                        : ((OFF_TICKS > GAP_TICKS) ? OFF_TICKS : GAP_TICKS);
    localparam int TW   = $clog2(MAXT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_OFF,
        S_GAP
    } state_e;

    state_e              state_q, state_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [TW-1:0]       tick_q, tick_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic [GW-1:0]       last_q, last_d;
    logic [GW-1:0]       gid_q, gid_d;
    logic [NREQ-1:0]     ack_q, ack_d;
    logic                done_q, done_d;

    logic [CNT_W-1:0]    cnt_arr [NREQ];
    logic                win_vld;
    logic [GW-1:0]       win_idx;
    logic [CNT_W-1:0]    win_cnt;
    logic [TW-1:0]       phase_last;
    logic                phase_end;
    int                  cand;
    logic [GW-1:0]       cand_idx;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign cnt_arr[g] = count[g*CNT_W +: CNT_W];
    end

    // Search starts one past the last requester served and wraps around.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = int'(last_q) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            cand_idx = GW'(cand);
            if (!win_vld && req[cand_idx]) begin
                win_vld = 1'b1;
                win_idx = cand_idx;
            end
        end
    end

    assign win_cnt = cnt_arr[win_idx];

    always_comb begin
        phase_last = '0;
        case (state_q)
            S_ON:    phase_last = TW'(ON_TICKS - 1);
            S_OFF:   phase_last = TW'(OFF_TICKS - 1);
            S_GAP:   phase_last = TW'(GAP_TICKS - 1);
            default: phase_last = '0;
        endcase
    end

    assign phase_end = (presc_q == PW'(TICK_DIV - 1)) && (tick_q == phase_last);

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        last_d  = last_q;
        gid_d   = gid_q;
        ack_d   = '0;
        done_d  = 1'b0;
        if (presc_q == PW'(TICK_DIV - 1)) begin
            presc_d = '0;
            tick_d  = tick_q + TW'(1);
        end else begin
            presc_d = presc_q + PW'(1);
            tick_d  = tick_q;
        end

        case (state_q)
            S_IDLE: begin
                // A zero-count request is acknowledged but never leaves IDLE.
                if (win_vld) begin
                    ack_d[win_idx] = 1'b1;
                    last_d         = win_idx;
                    if (win_cnt != '0) begin
                        rem_d   = win_cnt;
                        gid_d   = win_idx;
                        state_d = S_ON;
                    end
                end
            end
            S_ON: begin
                if (phase_end) begin
                    rem_d   = rem_q - CNT_W'(1);
                    state_d = S_OFF;
                end
            end
            S_OFF: begin
                if (phase_end) state_d = (rem_q != '0) ? S_ON : S_GAP;
            end
            S_GAP: begin
                if (phase_end) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Every phase starts from a clean prescaler so its length is exact.
        if (state_d != state_q || state_q == S_IDLE) begin
            presc_d = '0;
            tick_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            tick_q  <= '0;
            rem_q   <= '0;
            last_q  <= GW'(NREQ - 1);
            gid_q   <= '0;
            ack_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            rem_q   <= rem_d;
            last_q  <= last_d;
            gid_q   <= gid_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
        end
    end

    assign led      = (state_q == S_ON);
    assign busy     = (state_q != S_IDLE);
    assign ack      = ack_q;
    assign done     = done_q;
    assign grant_id = gid_q;

    ack_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(ack));

endmodule

// File: doc/led_blink_arbiter.md
# led_blink_arbiter

Shares the board's single status LED among several requesters that each want to flash a blink code (N pulses, then a pause). It sits between the status sources and the LED pin, and takes over from the free-running blinker. Requests are served whole, one at a time, in round-robin order. All timing comes from an internal prescaler driven by the board clock.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- CNT_W, 4, width of each blink-count field
- TICK_DIV, 25000, clk cycles per timing tick (≥2)
- ON_TICKS, 200, ticks LED is on per pulse (≥1)
- OFF_TICKS, 200, ticks LED is off between/after pulses (≥1)
- GAP_TICKS, 1000, ticks of enforced dark pause after a code (≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  NREQ  level request per requester
- count  in  NREQ*CNT_W  blink count per requester; field i = count[i*CNT_W +: CNT_W]
- ack  out  NREQ  one-cycle pulse when request i is accepted; count is latched at that point
- done  out  1  one-cycle pulse when the code finishes (end of GAP)
- busy  out  1  high in any state other than IDLE
- grant_id  out  clog2(NREQ)  index of the requester being served, held until the next grant
- led  out  1  LED drive, active high

## Operation
- FSM states: IDLE, ON, OFF, GAP.
- IDLE:
  - Round-robin search starts at last_grant+1 and wraps modulo NREQ.
  - The first i with req[i]=1 wins.
  - If count[i]≠0: latch remaining=count[i], grant_id=i, last_grant=i, pulse ack[i], go to ON.
  - If count[i]=0: pulse ack[i], set last_grant=i, stay in IDLE. No blink and no done.
- ON: led=1 for ON_TICKS ticks, then go to OFF and decrement remaining.
- OFF: led=0 for OFF_TICKS ticks, then go to ON if remaining≠0, else go to GAP.
- GAP: led=0 for GAP_TICKS ticks, then pulse done and go to IDLE.
- Prescaler and tick counter clear on every state entry.
  - A phase of P ticks therefore lasts exactly P*TICK_DIV clk cycles.
- req is a level signal. A requester still asserting req after its ack is treated as a new request and re-arbitrated normally.
- req and count changes while busy are ignored. Only the value latched at grant is used.
- At most one ack bit is high in any cycle.
- remaining is CNT_W bits wide; the maximum code length is 2^CNT_W−1 pulses.

## Timing
- Reset (async assert, synchronous release) sets:
  - state=IDLE, led=0, ack=0, done=0, busy=0, grant_id=0
  - last_grant=NREQ−1, so requester 0 has first priority after reset
  - prescaler and counters = 0
- Reset asserted mid-code aborts immediately. led drops asynchronously, and no done is issued.
- Grant latency: req[i] sampled high in IDLE at edge k gives, from edge k:
  - ack[i]=1 for one cycle
  - led=1, busy=1, grant_id=i
- Code duration from the grant edge to the done edge is (count*(ON_TICKS+OFF_TICKS)+GAP_TICKS)*TICK_DIV cycles.
- done and the return to IDLE (busy=0, led=0) occur on the same edge.
- The next grant can happen on the edge after done, which gives one IDLE cycle between codes.
- A zero-count ack takes one cycle. Consecutive zero-count requests are acked on consecutive cycles.

## Test plan
Parameters for all scenarios: TICK_DIV=4, ON_TICKS=2, OFF_TICKS=3, GAP_TICKS=5, NREQ=4.
- Reset then single request: req=0001, count0=3.
  - ack=0001 and led rises on the same edge.
  - led is high for 8 cycles and low for 12 cycles, repeated 3 times.
  - This is followed by 20 dark cycles, then done.
  - Grant to done = 80 cycles; busy is high for exactly 80 cycles.
- Round-robin: req=1111 held, all counts=1.
  - Grant order is 0,1,2,3,0.
  - Each code is 40 cycles, with one IDLE cycle between codes.
- Zero count: req=0110 with count1=0 and count2=2.
  - ack=0010 with no led activity.
  - On the next cycle, ack=0100 and a 60-cycle code runs on id 2.
- Ignore changes while busy: during requester 0's code, change count0 to 9 and assert req3.
  - Requester 0 still blinks its latched count.
  - Requester 3 is granted after done.
- Reset mid-operation: assert rst_n=0 during ON.
  - led=0 and busy=0 immediately, with no done.
  - After release, req=1001 grants requester 0 first.
- Maximum count: count=15.
  - Exactly 15 led pulses; grant to done = 320 cycles.
